opfetch: RTL and testbench

Operand-fetch and scoreboard stage that drives the read and write ports of the integer register file. It sits between decode and execute in the RV32E core. It accepts decoded instructions, reads rs1/rs2 from the register file and forwards same-cycle writeback data. It stalls on read-after-write and write-after-write hazards using a per-register busy bitmap, then presents operands to execute through a one-entry registered output. It is also the single writer of the register file: writeback results pass through it to the register-file write port.

---
 rtl/opfetch_pkg.sv | 21 ++
 rtl/opfetch_scoreboard.sv | 56 +++++
 rtl/opfetch.sv | 94 +++++++++
 tb/tb_opfetch.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/opfetch_pkg.sv
// Shared constants and types for the operand-fetch stage and the integer register file.
package opfetch_pkg;
  localparam int N_REGS   = 16;
  localparam int REG_ID_W = 5;
  localparam int XLEN     = 32;
  localparam int IDX_W    = $clog2(N_REGS);

  typedef enum logic {OF_EMPTY, OF_FULL} of_state_t;

  typedef struct packed {
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [REG_ID_W-1:0] rd;
    logic                rd_wen;
  } op_t;

  // x0 and indices beyond the RV32E file are never tracked or written.
  function automatic logic is_real(input logic [REG_ID_W-1:0] r);
    return (r != '0) && (r < REG_ID_W'(N_REGS));
  endfunction
endpackage

// File: rtl/opfetch_scoreboard.sv
// Per-register busy bitmap with writeback clear, issue set and the sticky orphan-writeback flag.
module opfetch_scoreboard
  import opfetch_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                set_en,
  input  logic [REG_ID_W-1:0] set_rd,
  input  logic                wb_valid,
  input  logic [REG_ID_W-1:0] wb_rd,
  input  logic [REG_ID_W-1:0] rs1,
  input  logic [REG_ID_W-1:0] rs2,
  input  logic [REG_ID_W-1:0] rd,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic                rd_busy,
  output logic                rs1_byp,
  output logic                rs2_byp,
  output logic                sb_err
);
  logic [N_REGS-1:0] busy_q, busy_d, set_vec, clr_vec, eff_busy;
  logic              err_set;

  function automatic logic pick(input logic [N_REGS-1:0] vec, input logic [REG_ID_W-1:0] idx);
    return is_real(idx) ? vec[idx[IDX_W-1:0]] : 1'b0;
  endfunction

  assign set_vec[0] = 1'b0;
  assign clr_vec[0] = 1'b0;

  for (genvar r = 1; r < N_REGS; r++) begin : g_reg
    assign set_vec[r] = set_en   && (set_rd == REG_ID_W'(r));
    assign clr_vec[r] = wb_valid && (wb_rd  == REG_ID_W'(r));
  end

  // Set after clear: a younger writer issued alongside the writeback keeps the bit.
  assign busy_d   = (busy_q & ~clr_vec) | set_vec;
  assign eff_busy = busy_q & ~clr_vec;

  assign rs1_busy = pick(eff_busy, rs1);
  assign rs2_busy = pick(eff_busy, rs2);
  assign rd_busy  = pick(eff_busy, rd);
  assign rs1_byp  = pick(clr_vec, rs1);
  assign rs2_byp  = pick(clr_vec, rs2);
  assign err_set  = wb_valid && is_real(wb_rd) && !pick(busy_q, wb_rd);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (err_set) sb_err <= 1'b1;
    end
  end
endmodule

// File: rtl/opfetch.sv
// Operand fetch: hazard stall, writeback bypass, one-entry operand register and register-file write port.
module opfetch
  import opfetch_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                iss_valid,
  output logic                iss_ready,
  input  logic [REG_ID_W-1:0] iss_rs1,
  input  logic [REG_ID_W-1:0] iss_rs2,
  input  logic [REG_ID_W-1:0] iss_rd,
  input  logic                iss_rd_wen,
  input  logic                wb_valid,
  input  logic [REG_ID_W-1:0] wb_rd,
  input  logic [XLEN-1:0]     wb_data,
  output logic [REG_ID_W-1:0] rf_rs1,
  output logic [REG_ID_W-1:0] rf_rs2,
  input  logic [XLEN-1:0]     rf_rdata1,
  input  logic [XLEN-1:0]     rf_rdata2,
  output logic                rf_wen,
  output logic [REG_ID_W-1:0] rf_rd,
  output logic [XLEN-1:0]     rf_wdata,
  output logic                op_valid,
  input  logic                op_ready,
  output logic [XLEN-1:0]     op_a,
  output logic [XLEN-1:0]     op_b,
  output logic [REG_ID_W-1:0] op_rd,
  output logic                op_rd_wen,
  output logic                sb_err
);
  of_state_t       state_q, state_d;
  op_t             op_q;
  logic            rs1_busy, rs2_busy, rd_busy, rs1_byp, rs2_byp;
  logic            stall, accept;
  logic [XLEN-1:0] src_a, src_b;

  assign rf_rs1   = iss_rs1;
  assign rf_rs2   = iss_rs2;
  assign rf_wen   = wb_valid && is_real(wb_rd);
  assign rf_rd    = wb_rd;
  assign rf_wdata = wb_data;

  assign stall     = rs1_busy || rs2_busy || (iss_rd_wen && rd_busy) ||
                     ((state_q == OF_FULL) && !op_ready);
  assign iss_ready = !stall;
  assign accept    = iss_valid && iss_ready;

  // Same-cycle writeback wins over the file, whose write only lands at the edge.
  assign src_a = !is_real(iss_rs1) ? '0 : (rs1_byp ? wb_data : rf_rdata1);
  assign src_b = !is_real(iss_rs2) ? '0 : (rs2_byp ? wb_data : rf_rdata2);

  opfetch_scoreboard u_sb (
    .clock    (clock),
    .reset    (reset),
    .set_en   (accept && iss_rd_wen && is_real(iss_rd)),
    .set_rd   (iss_rd),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .rs1      (iss_rs1),
    .rs2      (iss_rs2),
    .rd       (iss_rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy),
    .rs1_byp  (rs1_byp),
    .rs2_byp  (rs2_byp),
    .sb_err   (sb_err)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= OF_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OF_EMPTY: if (accept) state_d = OF_FULL;
      OF_FULL:  if (op_ready && !accept) state_d = OF_EMPTY;
      default:  state_d = OF_EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) op_q <= '0;
    else if (accept) op_q <= '{a: src_a, b: src_b, rd: iss_rd, rd_wen: iss_rd_wen};
  end

  assign op_valid  = (state_q == OF_FULL);
  assign op_a      = op_q.a;
  assign op_b      = op_q.b;
  assign op_rd     = op_q.rd;
  assign op_rd_wen = op_q.rd_wen;
endmodule

// File: tb/tb_opfetch.sv
// Randomized scoreboard bench for opfetch with a register-level reference model and a register file.
module tb_opfetch;
  import opfetch_pkg::*;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                iss_valid = 1'b0, iss_ready, iss_rd_wen = 1'b0;
  logic [REG_ID_W-1:0] iss_rs1 = '0, iss_rs2 = '0, iss_rd = '0;
  logic                wb_valid = 1'b0;
  logic [REG_ID_W-1:0] wb_rd = '0;
  logic [XLEN-1:0]     wb_data = '0;
  logic [REG_ID_W-1:0] rf_rs1, rf_rs2, rf_rd, op_rd;
  logic [XLEN-1:0]     rf_rdata1, rf_rdata2, rf_wdata, op_a, op_b;
  logic                rf_wen, op_valid, op_ready = 1'b0, op_rd_wen, sb_err;

  always #5 clock = ~clock;

  opfetch dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_rd_wen(iss_rd_wen),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .op_rd(op_rd), .op_rd_wen(op_rd_wen), .sb_err(sb_err)
  );

  // Environment register file, written only through the DUT write port.
  logic [XLEN-1:0] rf [N_REGS];
  function automatic bit tb_real(input int r);
    return (r != 0) && (r < N_REGS);
  endfunction
  assign rf_rdata1 = tb_real(int'(rf_rs1)) ? rf[rf_rs1[IDX_W-1:0]] : '0;
  assign rf_rdata2 = tb_real(int'(rf_rs2)) ? rf[rf_rs2[IDX_W-1:0]] : '0;
  always @(posedge clock) if (rf_wen) rf[rf_rd[IDX_W-1:0]] <= rf_wdata;

  // Reference model: architectural values, pending writers, in-flight operand bundles.
  logic [XLEN-1:0] mrf [N_REGS];
  bit              mbusy [N_REGS];
  bit              merr;
  op_t             q[$];
  int              compared = 0, mismatched = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pending(input int s, input bit wbv, input int wbrd);
    return tb_real(s) && mbusy[s] && !(wbv && wbrd == s);
  endfunction

  function automatic logic [XLEN-1:0] srcval(input int s, input bit wbv, input int wbrd,
                                             input logic [XLEN-1:0] wbd);
    if (!tb_real(s)) return '0;
    if (wbv && wbrd == s) return wbd;
    return mrf[s];
  endfunction

  task automatic cycle(input bit iv, input int rs1, input int rs2, input int rd, input bit wen,
                       input bit wbv, input int wbrd, input logic [XLEN-1:0] wbd, input bit ordy);
    bit  exp_ready;
    op_t e;
    @(negedge clock); #1;
    iss_valid = iv; iss_rs1 = REG_ID_W'(rs1); iss_rs2 = REG_ID_W'(rs2);
    iss_rd = REG_ID_W'(rd); iss_rd_wen = wen;
    wb_valid = wbv; wb_rd = REG_ID_W'(wbrd); wb_data = wbd; op_ready = ordy;
    #2;
    exp_ready = !(pending(rs1, wbv, wbrd) || pending(rs2, wbv, wbrd) ||
                  (wen && pending(rd, wbv, wbrd)) || (q.size() != 0 && !ordy));
    check("iss_ready", {31'b0, iss_ready}, {31'b0, exp_ready});
    check("rf_wen", {31'b0, rf_wen}, {31'b0, wbv && tb_real(wbrd)});
    if (wbv && tb_real(wbrd)) begin
      check("rf_rd", {27'b0, rf_rd}, XLEN'(wbrd));
      check("rf_wdata", rf_wdata, wbd);
    end
    check("sb_err", {31'b0, sb_err}, {31'b0, merr});
    if (iv && exp_ready) begin
      e.a = srcval(rs1, wbv, wbrd, wbd);
      e.b = srcval(rs2, wbv, wbrd, wbd);
      e.rd = REG_ID_W'(rd);
      e.rd_wen = wen;
      q.push_back(e);
    end
    if (wbv && tb_real(wbrd)) begin
      if (!mbusy[wbrd]) merr = 1'b1;
      mbusy[wbrd] = 1'b0;
      mrf[wbrd] = wbd;
    end
    if (iv && exp_ready && wen && tb_real(rd)) mbusy[rd] = 1'b1;
  endtask

  // Asserted mid-cycle: effects must be visible before any clock edge.
  task automatic do_reset();
    @(negedge clock); #1;
    iss_valid = 1'b0; wb_valid = 1'b0;
    iss_rs1 = 5'd2; iss_rs2 = 5'd0; iss_rd = 5'd2; iss_rd_wen = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("rst_op_valid", {31'b0, op_valid}, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_op_rd", {27'b0, op_rd}, 32'd0);
    check("rst_op_rd_wen", {31'b0, op_rd_wen}, 32'd0);
    check("rst_sb_err", {31'b0, sb_err}, 32'd0);
    check("rst_ready", {31'b0, iss_ready}, 32'd1);
    q.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    merr = 1'b0;
    @(negedge clock); #1 reset = 1'b0;
  endtask

  // Monitor: compares the presented bundle against the oldest expected one.
  initial begin
    forever begin
      @(negedge clock); #2;
      if (!reset) begin
        check("op_valid", {31'b0, op_valid}, {31'b0, q.size() != 0});
        if (op_valid && q.size() != 0) begin
          check("op_a", op_a, q[0].a);
          check("op_b", op_b, q[0].b);
          check("op_rd", {27'b0, op_rd}, {27'b0, q[0].rd});
          check("op_rd_wen", {31'b0, op_rd_wen}, {31'b0, q[0].rd_wen});
          if (op_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    int bl[$];
    for (int i = 0; i < N_REGS; i++) begin
      rf[i] = (i == 0) ? '0 : $urandom;
      mrf[i] = rf[i];
    end
    rf[3] = 32'h11; mrf[3] = 32'h11;
    do_reset();

    // Directed: read x3, busy x5, RAW stall, bypass release.
    cycle(1, 3, 0, 5, 1, 0, 0, 0, 1);
    cycle(1, 5, 0, 6, 1, 0, 0, 0, 1);
    cycle(1, 5, 0, 6, 1, 1, 5, 32'hDEAD, 1);
    // WAW on x7, released by its writeback while the bit stays set.
    cycle(1, 0, 0, 7, 1, 0, 0, 0, 1);
    cycle(1, 1, 2, 7, 1, 0, 0, 0, 1);
    cycle(1, 1, 2, 7, 1, 1, 7, 32'h77, 1);
    cycle(1, 7, 0, 0, 0, 0, 0, 0, 1);
    // Backpressure then release with a same-cycle accept.
    cycle(1, 1, 2, 3, 0, 0, 0, 0, 1);
    cycle(1, 2, 1, 4, 0, 0, 0, 0, 0);
    cycle(1, 2, 1, 4, 0, 0, 0, 0, 0);
    cycle(1, 2, 1, 4, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Writebacks to non-real registers, then an orphan writeback.
    cycle(0, 0, 0, 0, 0, 1, 0, 32'h1, 1);
    cycle(0, 0, 0, 0, 0, 1, 16, 32'h2, 1);
    cycle(0, 0, 0, 0, 0, 1, 31, 32'h3, 1);
    cycle(0, 0, 0, 0, 0, 1, 6, 32'h66, 1);
    cycle(0, 0, 0, 0, 0, 1, 7, 32'h78, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 1, 4, 32'h44, 1);
    cycle(1, 4, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    // Full with x2 busy, then asynchronous reset.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 2, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      int pk[3];
      bit wbv;
      int wbrd;
      for (int k = 0; k < 3; k++)
        pk[k] = ($urandom_range(0, 15) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 15));
      bl.delete();
      for (int i = 1; i < N_REGS; i++) if (mbusy[i]) bl.push_back(i);
      wbv = 1'b0; wbrd = 0;
      if (bl.size() != 0 && $urandom_range(0, 1) == 1) begin
        wbv = 1'b1; wbrd = bl[$urandom_range(0, bl.size() - 1)];
      end else if ($urandom_range(0, 63) == 0) begin
        wbv = 1'b1; wbrd = $urandom_range(0, 31);
      end
      cycle($urandom_range(0, 3) != 0, pk[0], pk[1], pk[2], $urandom_range(0, 4) != 0,
            wbv, wbrd, $urandom, $urandom_range(0, 3) != 0);
      if (n % 700 == 699) do_reset();
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
